// File: rtl/t1_pkg.sv
// t1_pkg: shared FSM state types, packet layout and segment staging record
package t1_pkg;
   typedef enum logic {FETCH, FULL} fetch_state_t;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} exec_state_t;
   localparam int HDR_BYTES = 2;
   localparam int MAX_AXES  = 8;
   typedef struct packed {
      logic [15:0]                dur;
      logic [MAX_AXES-1:0][7:0]   mag;
      logic [MAX_AXES-1:0]        dir;
   } segment_t;
   // |s| limited to the segment duration; -128 maps to 128 before limiting
   function automatic logic [7:0] clamp_mag(input logic [7:0] s, input logic [15:0] d);
      logic [7:0] a;
      a = s[7] ? 8'(-s) : s;
      return ({8'd0, a} > d) ? d[7:0] : a;
   endfunction
endpackage

// File: rtl/t1_axis_dda.sv
// t1_axis_dda: one-axis DDA step spreader with step pulse stretcher
module t1_axis_dda import t1_pkg::*; #(
   parameter int DUR_W   = 16,
   parameter int PULSE_W = 5
) (
   input  logic             clk,
   input  logic             N_reset,
   input  logic             load,
   input  logic             tick,
   input  logic [7:0]       m,
   input  logic [DUR_W-1:0] D,
   output logic             step,
   output logic             pulse_active
);
   localparam int AW = DUR_W + 1;
   localparam int PW = $clog2(PULSE_W + 1);
   logic [7:0]    mag;
   logic [AW-1:0] acc, sum;
   logic          fire;
   logic [PW-1:0] pcnt;
   assign sum          = acc + AW'(mag);
   assign fire         = tick && sum >= {1'b0, D};
   assign step         = pcnt != '0;
   assign pulse_active = step;
   // accumulate m per tick, wrap by D and stretch each overflow into a pulse
   always_ff @(posedge clk) begin
      if (!N_reset) begin
         mag  <= '0;
         acc  <= '0;
         pcnt <= '0;
      end else begin
         if (load) begin
            mag <= m;
            acc <= '0;
         end else if (tick) acc <= fire ? sum - {1'b0, D} : sum;
         pcnt <= fire ? PW'(PULSE_W) : pcnt - PW'(step);
      end
   end
endmodule

// File: rtl/t1_core.sv
// t1_core: segment byte-stream fetch, one-deep staging and multi-axis step/dir generation
module t1_core import t1_pkg::*; #(
   parameter int NUM_AXES = 3,
   parameter int TICK_DIV = 25,
   parameter int PULSE_W  = 5,
   parameter int DUR_W    = 16
) (
   input  logic                clk,
   input  logic                N_reset,
   input  logic                data_ready,
   input  logic [7:0]          data,
   output logic                data_request,
   output logic [0:NUM_AXES-1] step,
   output logic [0:NUM_AXES-1] dir,
   output logic                busy
);
   localparam int CW = $clog2(TICK_DIV);
   fetch_state_t        fetch_q, fetch_d;
   exec_state_t         exec_q, exec_d;
   segment_t            stage;
   logic                rdy_q, accept, last_byte, ld, ld_run, tick, seg_done, any_pulse;
   logic [3:0]          idx;
   logic [2:0]          slot;
   logic [CW-1:0]       cnt;
   logic [DUR_W-1:0]    dur, tk;
   logic [NUM_AXES-1:0] pact;
   assign accept    = data_request && data_ready && !rdy_q;
   assign last_byte = accept && idx == 4'(NUM_AXES + HDR_BYTES - 1);
   assign slot      = 3'(idx - 4'(HDR_BYTES));
   assign any_pulse = |pact;
   assign ld        = fetch_q == FULL && exec_q != RUN && !any_pulse;
   assign ld_run    = ld && stage.dur != '0;
   assign tick      = exec_q == RUN && cnt == CW'(TICK_DIV - 1);
   assign seg_done  = tick && tk == dur - DUR_W'(1);
   assign busy      = exec_q != IDLE || fetch_q == FULL;
   // fetch and exec state registers
   always_ff @(posedge clk) begin
      if (!N_reset) begin
         fetch_q <= FETCH;
         exec_q  <= IDLE;
      end else begin
         fetch_q <= fetch_d;
         exec_q  <= exec_d;
      end
   end
   // fetch fills staging until the last byte, then waits for the load to drain it
   always_comb begin
      fetch_d = fetch_q == FETCH ? (last_byte ? FULL : FETCH) : (ld ? FETCH : FULL);
   end
   // exec runs D ticks, then drains until pulses end, chaining straight into a staged load
   always_comb begin
      exec_d = exec_q;
      if (exec_q == RUN) exec_d = seg_done ? DRAIN : RUN;
      else if (ld_run) exec_d = RUN;
      else if (!any_pulse) exec_d = IDLE;
   end
   // byte handshake, staging capture, load of direction/duration and tick timing
   always_ff @(posedge clk) begin
      if (!N_reset) begin
         rdy_q        <= 1'b0;
         data_request <= 1'b0;
         idx          <= '0;
         stage        <= '0;
         dur          <= '0;
         tk           <= '0;
         cnt          <= '0;
         dir          <= '0;
      end else begin
         rdy_q        <= data_ready;
         data_request <= fetch_d == FETCH && !accept;
         if (accept) begin
            idx <= last_byte ? 4'd0 : idx + 4'd1;
            if (idx == 4'd0) stage.dur[7:0] <= data;
            else if (idx == 4'd1) stage.dur[15:8] <= data;
            else begin
               stage.mag[slot] <= clamp_mag(data, stage.dur);
               stage.dir[slot] <= !data[7];
            end
         end
         if (ld_run) begin
            dur <= DUR_W'(stage.dur);
            tk  <= '0;
            cnt <= '0;
            for (int a = 0; a < NUM_AXES; a++) dir[a] <= stage.dir[a];
         end else if (exec_q == RUN) begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) tk <= tk + DUR_W'(1);
         end
      end
   end
   for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
      t1_axis_dda #(.DUR_W(DUR_W), .PULSE_W(PULSE_W)) u_dda (
         .clk(clk), .N_reset(N_reset), .load(ld_run), .tick(tick), .m(stage.mag[i]),
         .D(dur), .step(step[i]), .pulse_active(pact[i])
      );
   end
endmodule

// File: tb/tb_t1_core.sv
// tb_t1_core: directed stimulus with a step-event scoreboard for t1_core
module tb_t1_core;
   localparam int NA = 3, TD = 4, PW = 2;
   logic          clk = 1'b0, N_reset = 1'b0, data_ready = 1'b0;
   logic [7:0]    data = 8'h00;
   logic          data_request, busy;
   logic [0:NA-1] step, dir;
   typedef struct {int axis; int cyc; logic d;} ev_t;
   ev_t q[$];
   ev_t e;
   int total = 0, bad = 0, cyc = 0, last_acc = 0, free_at = 0, last_load = 0;
   logic [0:NA-1] prev = '0;
   int wid [NA];

   t1_core #(.NUM_AXES(NA), .TICK_DIV(TD), .PULSE_W(PW), .DUR_W(16)) dut (
      .clk(clk), .N_reset(N_reset), .data_ready(data_ready), .data(data),
      .data_request(data_request), .step(step), .dir(dir), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      while (data_request !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
      chk("req_wait", 32'(data_request === 1'b1), 1);
      data = b; data_ready = 1'b1; last_acc = cyc;
      @(posedge clk); #1;
      data_ready = 1'b0;
      chk("req_drop", data_request, 0);
   endtask

   // expected step events from the DDA definition; load waits for the previous segment
   task automatic post_pkt(input int d, input int s0, input int s1, input int s2);
      int s [3];
      int m [3];
      int acc [3];
      int l, mag;
      bit any;
      ev_t x;
      s[0] = s0; s[1] = s1; s[2] = s2;
      l = (last_acc + 1 > free_at) ? last_acc + 1 : free_at;
      any = 0;
      for (int a = 0; a < NA; a++) begin
         mag = s[a] < 0 ? -s[a] : s[a];
         m[a] = mag > d ? d : mag;
         acc[a] = 0;
         if (m[a] > 0) any = 1;
      end
      for (int k = 1; k <= d; k++)
         for (int a = 0; a < NA; a++) begin
            acc[a] += m[a];
            if (acc[a] >= d) begin
               acc[a] -= d;
               x.axis = a; x.cyc = l + k * TD + 1; x.d = s[a] >= 0;
               q.push_back(x);
            end
         end
      last_load = l;
      free_at = (d == 0) ? l + 1 : l + d * TD + (any ? PW + 1 : 1);
   endtask

   task automatic send_pkt(input logic [7:0] b0, b1, b2, b3, b4);
      send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
      post_pkt(int'({b1, b0}), int'($signed(b2)), int'($signed(b3)), int'($signed(b4)));
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy !== 1'b0 || q.size() != 0) && n < 3000) begin @(posedge clk); #1; n++; end
      chk("idle_reached", 32'(n < 3000), 1);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   always @(negedge clk) begin
      if (!N_reset) begin
         prev = '0;
         for (int a = 0; a < NA; a++) wid[a] = 0;
      end else begin
         for (int a = 0; a < NA; a++) begin
            if (step[a] && !prev[a]) begin
               if (q.size() == 0) chk("step_expected", q.size(), 1);
               else begin
                  e = q.pop_front();
                  chk("step_axis", a, e.axis);
                  chk("step_cyc", cyc, e.cyc);
                  chk("step_dir", dir[a], e.d);
               end
            end
            if (step[a]) wid[a]++;
            else if (prev[a]) begin
               chk("pulse_w", wid[a], PW);
               wid[a] = 0;
            end
         end
         prev = step;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", data_request, 0);
      chk("rst_step", step, 0);
      chk("rst_dir", dir, 0);
      chk("rst_busy", busy, 0);
      N_reset = 1'b1;
      @(posedge clk); #1;
      chk("req_after_rst", data_request, 1);
      // basic segment
      send_pkt(8'h0A, 8'h00, 8'h05, 8'hFB, 8'h00);
      @(posedge clk); #1;
      chk("basic_dir", dir, 3'b101);
      wait_idle();
      // clamp
      send_pkt(8'h03, 8'h00, 8'h7F, 8'h80, 8'h01);
      wait_idle();
      chk("clamp_dir", dir, 3'b101);
      // zero duration: discarded, dir kept, next packet requested at once
      send_pkt(8'h00, 8'h00, 8'h05, 8'h05, 8'h05);
      chk("zero_busy_staged", busy, 1);
      @(posedge clk); #1;
      chk("zero_req", data_request, 1);
      chk("zero_idle", busy, 0);
      chk("zero_dir", dir, 3'b101);
      // prefetch: second packet staged while the first runs
      send_pkt(8'h04, 8'h00, 8'h02, 8'hFE, 8'h04);
      send_pkt(8'h02, 8'h00, 8'h01, 8'h01, 8'hFF);
      chk("pf_req_full", data_request, 0);
      chk("pf_busy", busy, 1);
      wait_cyc(last_load);
      chk("pf_req_at_load", data_request, 0);
      @(posedge clk); #1;
      chk("pf_req_after_load", data_request, 1);
      wait_idle();
      // handshake: held data_ready yields one accept only
      n = 0;
      while (data_request !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
      data = 8'h05; data_ready = 1'b1; last_acc = cyc;
      repeat (10) @(posedge clk);
      #1;
      chk("hs_busy", busy, 0);
      chk("hs_req", data_request, 1);
      data_ready = 1'b0;
      @(posedge clk); #1;
      send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      post_pkt(5, 1, 0, 0);
      wait_idle();
      // reset mid-segment with a partial packet pending
      send_pkt(8'h08, 8'h00, 8'h04, 8'h04, 8'h04);
      send_byte(8'h01); send_byte(8'h00);
      n = 0;
      while (step[0] !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      chk("rm_step_seen", step[0], 1);
      N_reset = 1'b0;
      @(posedge clk); #1;
      chk("rm_step", step, 0);
      chk("rm_busy", busy, 0);
      chk("rm_dir", dir, 0);
      chk("rm_req", data_request, 0);
      q.delete();
      free_at = 0;
      @(posedge clk); #1;
      N_reset = 1'b1;
      @(posedge clk); #1;
      chk("rm_req_rel", data_request, 1);
      send_pkt(8'h02, 8'h00, 8'h00, 8'h00, 8'h02);
      wait_idle();
      chk("final_queue", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/t1_core.md
# t1_core

Parametrised successor to the three-axis step/dir core: consumes a byte stream of motion segments over the `data_request`/`data_ready` handshake and drives `NUM_AXES` step/dir outputs. Each segment carries a duration and one signed step count per axis. Steps are spread evenly over the segment by a per-axis DDA (digital differential analyser). A one-deep staging buffer prefetches the next segment, so back-to-back segments run without waiting on the byte source.

## Interface
- `NUM_AXES`, 3, number of step/dir channels (1..8)
- `TICK_DIV`, 25, clocks per motion tick (≥2)
- `PULSE_W`, 5, step pulse high time in clocks (1..`TICK_DIV`-1)
- `DUR_W`, 16, segment duration width in ticks (fixed at 16 for the byte format)
- `clk`  in  1  system clock
- `N_reset`  in  1  synchronous, active-low reset
- `data_ready`  in  1  source has valid byte on `data`
- `data`  in  8  stream byte
- `data_request`  out  1  core wants a byte
- `step`  out  [0:NUM_AXES-1]  step pulses
- `dir`  out  [0:NUM_AXES-1]  direction, 1 = positive
- `busy`  out  1  segment executing or staged

## Operation
- Packet format is `2+NUM_AXES` bytes:
  - duration D, LSB first, in ticks;
  - then one signed 8-bit step count s per axis, axis 0 first.
- Handshake:
  - A byte is accepted on a clock where `data_request`=1, `data_ready`=1 and `data_ready` was 0 on the previous clock (registered rising-edge detect).
  - `data_request` goes 0 the clock after an accept and stays 0 for at least one clock.
  - `data_request` is held 0 while staging is full.
- Fetch FSM has two states:
  - FETCH: byte index 0..`NUM_AXES`+1.
  - FULL: staging valid. Entered on accept of the final byte; returns to FETCH on load.
- Exec FSM states are IDLE, RUN and DRAIN.
  - IDLE→RUN on load.
  - RUN→DRAIN after tick D.
  - DRAIN→IDLE when all step pulses have ended.
  - DRAIN→RUN (via load) directly if staging is full.
- Load occurs in one clock. It requires exec in IDLE or DRAIN, no step pulse active, and staging FULL.
- Actions on load:
  - latch D;
  - latch per-axis magnitude m = min(|s|, D), so s = -128 gives m = 128 before clamping;
  - set `dir` = (s ≥ 0) for every axis, including axes with s = 0;
  - clear accumulators and the tick counter.
- D = 0: the segment is discarded at load. No ticks or steps occur; `dir` is unchanged.
- Tick generation: the counter runs 0..`TICK_DIV`-1 and a tick fires on terminal count. The first tick fires `TICK_DIV` clocks after load.
- DDA per axis, at each tick:
  - acc += m (`DUR_W`+1 bits);
  - if acc ≥ D, then acc -= D and a step is emitted.
  - This yields exactly m steps per segment; the last step always lands on tick D when m > 0.
- Step pulse: `step` rises the clock after the tick and stays high for `PULSE_W` clocks.
- `busy` = (exec ≠ IDLE) or (fetch = FULL).
- Partial packets persist across idle periods; there is no timeout.

## Timing
- Reset values: `data_request`=0, `step`=0, `dir`=0, `busy`=0. All state clears (byte index 0, staging empty, exec IDLE).
- `data_request`=1 on the first clock after `N_reset` goes high.
- Reset mid-segment aborts the segment immediately: pulses are cut and partial packets are dropped.
- Last byte accept to load is 1 clock when exec is IDLE.
- Dir setup before the first step is ≥ `TICK_DIV` clocks. Dir hold after the last step falls is ≥ 1 clock, since load waits for pulses to end.
- Back-to-back segments: after the final tick of segment k, load of k+1 happens on the first clock with no active pulse, i.e. `PULSE_W`+1 clocks after the tick.
- If an accept and a load occur on the same clock, load wins for staging. A byte cannot be accepted then, since `data_request` is 0 in FULL.

## Structure
- Package `t1_pkg` holds:
  - `fetch_state_t` {FETCH, FULL};
  - `exec_state_t` {IDLE, RUN, DRAIN};
  - `HDR_BYTES`=2;
  - `segment_t` struct (duration plus per-axis magnitude and direction arrays).
- Sub-module `t1_axis_dda` covers one axis: magnitude, accumulator, step compare and pulse stretcher. It has inputs `load`, `tick`, `m` and `D`, and outputs `step` and `pulse_active`. The top instantiates it `NUM_AXES` times via generate.

## Test plan
- Reset: hold `N_reset`=0 for 3 clocks → all outputs 0; `data_request`=1 on the first clock after release.
- Basic segment (NUM_AXES=3, TICK_DIV=4, PULSE_W=2), bytes 0A 00 05 FB 00 →
  - dir = {1,0,1};
  - axes 0 and 1 each step 5 times, on ticks 2,4,6,8,10;
  - axis 2 never steps;
  - each pulse is 2 clocks wide.
- Clamp, bytes 03 00 7F 80 01 → axis 0 makes 3 steps (one per tick), axis 1 makes 3 steps with dir=0, axis 2 makes 1 step on tick 3.
- Zero duration, bytes 00 00 05 05 05 → no steps, `dir` unchanged, next packet requested immediately.
- Prefetch: two packets sent fast → second staged during the first segment (`data_request`=0 while FULL); gap between final tick and next load is exactly `PULSE_W`+1 clocks.
- Handshake: hold `data_ready`=1 continuously → only one byte accepted; reset asserted mid-segment → `step`=0 the next clock, and the partial packet is discarded.
